// File: rtl/segre_pkg.sv
// Shared memory-operation types for the segre core.
package segre_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

endpackage

// File: rtl/segre_store_buffer.sv
// Coalescing store buffer between MEM and the data cache: circular FIFO of
// word entries with byte masks, store-to-load forwarding and a 2-state drain FSM.
module segre_store_buffer
  import segre_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [31:0]       push_data_i,
  input  memop_data_type_e  push_type_i,
  output logic              push_ready_o,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  memop_data_type_e  ld_type_i,
  output logic              fwd_hit_o,
  output logic [31:0]       fwd_data_o,
  output logic              fwd_partial_o,
  input  logic              cache_idle_i,
  input  logic              drain_req_i,
  output logic              dc_wr_o,
  output logic [ADDR_W-1:0] dc_addr_o,
  output logic [31:0]       dc_data_o,
  output logic [3:0]        dc_be_o,
  input  logic              dc_ack_i,
  output logic              draining_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WA_W  = ADDR_W - 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic { IDLE, ISSUE } state_e;

  function automatic logic [3:0] lane_mask(input memop_data_type_e t, input logic [1:0] off);
    logic [3:0] m;
    case (t)
      BYTE:    m = 4'b0001 << off;
      HALF:    m = off[1] ? 4'b1100 : 4'b0011;
      WORD:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic lane_aligned(input memop_data_type_e t, input logic [1:0] off);
    logic ok;
    case (t)
      BYTE:    ok = 1'b1;
      HALF:    ok = ~off[0];
      WORD:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] byte_expand(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  logic [WA_W-1:0]  addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       mask_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q, tail_q, young;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic             flush_q, flush_d;

  logic [WA_W-1:0]  push_wa;
  logic [1:0]       push_off;
  logic [3:0]       push_mask;
  logic [31:0]      push_lanes, push_bits;
  logic             full, push_coalesce, push_ok, do_merge, do_alloc, do_pop;

  assign push_wa    = push_addr_i[ADDR_W-1:2];
  assign push_off   = push_addr_i[1:0];
  assign push_mask  = lane_mask(push_type_i, push_off);
  assign push_bits  = byte_expand(push_mask);
  assign push_lanes = (push_data_i << {push_off, 3'b000}) & push_bits;
  assign young      = tail_q - PTR_W'(1);
  assign full       = (count_q == FULL_CNT);

  // The head being written to the cache is frozen; merging into it would
  // change data the cache may already have latched.
  assign push_coalesce = (count_q != '0) && (addr_q[young] == push_wa)
                         && !((state_q == ISSUE) && (young == head_q));
  assign push_ready_o  = !full || push_coalesce;
  assign push_ok       = push_i && push_ready_o && lane_aligned(push_type_i, push_off);
  assign do_merge      = push_ok && push_coalesce;
  assign do_alloc      = push_ok && !push_coalesce;
  assign do_pop        = (state_q == ISSUE) && dc_ack_i;
  assign count_d       = count_q + CNT_W'(do_alloc) - CNT_W'(do_pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((count_q != '0) && (cache_idle_i || full || flush_q)) state_d = ISSUE;
      ISSUE:   if (dc_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_d = flush_q;
    if (count_d == '0)    flush_d = 1'b0;
    else if (drain_req_i) flush_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      flush_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      if (do_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (do_alloc) begin
        addr_q[tail_q]  <= push_wa;
        data_q[tail_q]  <= push_lanes;
        mask_q[tail_q]  <= push_mask;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (do_merge) begin
        data_q[young] <= (data_q[young] & ~push_bits) | push_lanes;
        mask_q[young] <= mask_q[young] | push_mask;
      end
    end
  end

  logic [WA_W-1:0]  ld_wa;
  logic [1:0]       ld_off;
  logic [3:0]       ld_mask, hit_bytes;
  logic [PTR_W-1:0] scan_idx, fwd_idx;
  logic             fwd_found;

  assign ld_wa   = ld_addr_i[ADDR_W-1:2];
  assign ld_off  = ld_addr_i[1:0];
  assign ld_mask = lane_mask(ld_type_i, ld_off);

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (valid_q[scan_idx] && (addr_q[scan_idx] == ld_wa)) begin
        fwd_found = 1'b1;
        fwd_idx   = scan_idx;
      end
    end
  end

  assign hit_bytes     = mask_q[fwd_idx] & ld_mask;
  assign fwd_hit_o     = fwd_found && (ld_mask != 4'b0000) && (hit_bytes == ld_mask);
  assign fwd_partial_o = fwd_found && (hit_bytes != 4'b0000) && (hit_bytes != ld_mask);
  assign fwd_data_o    = fwd_found
                         ? ((data_q[fwd_idx] & byte_expand(hit_bytes)) >> {ld_off, 3'b000})
                         : '0;

  assign dc_wr_o    = (state_q == ISSUE);
  assign dc_addr_o  = {addr_q[head_q], 2'b00};
  assign dc_data_o  = data_q[head_q];
  assign dc_be_o    = mask_q[head_q];
  assign draining_o = flush_q || (state_q == ISSUE);
  assign empty_o    = (count_q == '0);

endmodule

// File: tb/tb_segre_store_buffer.sv
// Scoreboard bench for segre_store_buffer: a queue model of buffered entries
// predicts push_ready_o and every cache write; forwarding uses fixed expectations.
module tb_segre_store_buffer;
  import segre_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;

  logic             clk_i, rsn_i;
  logic             push_i;
  logic [31:0]      push_addr_i, push_data_i;
  memop_data_type_e push_type_i, ld_type_i;
  logic             push_ready_o;
  logic [31:0]      ld_addr_i;
  logic             fwd_hit_o, fwd_partial_o;
  logic [31:0]      fwd_data_o;
  logic             cache_idle_i, drain_req_i, dc_ack_i;
  logic             dc_wr_o, draining_o, empty_o;
  logic [31:0]      dc_addr_o, dc_data_o;
  logic [3:0]       dc_be_o;

  segre_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .push_i(push_i), .push_addr_i(push_addr_i), .push_data_i(push_data_i),
    .push_type_i(push_type_i), .push_ready_o(push_ready_o),
    .ld_addr_i(ld_addr_i), .ld_type_i(ld_type_i),
    .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o), .fwd_partial_o(fwd_partial_o),
    .cache_idle_i(cache_idle_i), .drain_req_i(drain_req_i),
    .dc_wr_o(dc_wr_o), .dc_addr_o(dc_addr_o), .dc_data_o(dc_data_o), .dc_be_o(dc_be_o),
    .dc_ack_i(dc_ack_i), .draining_o(draining_o), .empty_o(empty_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_push(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
    logic [3:0]  be;
    logic [31:0] lanes;
    bit          ok, merge, rdy;
    ent_t        e;
    case (t)
      BYTE:    begin be = 4'b0001 << a[1:0]; ok = 1'b1; end
      HALF:    begin be = a[1] ? 4'b1100 : 4'b0011; ok = !a[0]; end
      WORD:    begin be = 4'b1111; ok = (a[1:0] == 2'b00); end
      default: begin be = 4'b0000; ok = 1'b0; end
    endcase
    merge = (sb.size() > 0) && (sb[$].wa == a[31:2]);
    rdy   = (sb.size() < DEPTH) || merge;
    push_i = 1'b1; push_addr_i = a; push_data_i = d; push_type_i = t;
    #1;
    chk("push_ready", 32'(push_ready_o), 32'(rdy));
    tick();
    push_i = 1'b0;
    if (rdy && ok) begin
      lanes = d << (8 * a[1:0]);
      if (merge) e = sb.pop_back();
      else begin e.wa = a[31:2]; e.data = '0; e.be = '0; end
      for (int k = 0; k < 4; k++)
        if (be[k]) e.data[8*k +: 8] = lanes[8*k +: 8];
      e.be = e.be | be;
      sb.push_back(e);
    end
  endtask

  task automatic lookup(input logic [31:0] a, input memop_data_type_e t, input bit eh,
                        input bit ep, input bit chk_data, input logic [31:0] ed);
    ld_addr_i = a; ld_type_i = t;
    #1;
    chk("fwd_hit", 32'(fwd_hit_o), 32'(eh));
    chk("fwd_partial", 32'(fwd_partial_o), 32'(ep));
    if (chk_data) chk("fwd_data", fwd_data_o, ed);
  endtask

  task automatic wait_wr();
    int unsigned n = 0;
    while (dc_wr_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("dc_wr_seen", 32'(dc_wr_o), 32'd1);
  endtask

  task automatic check_head();
    ent_t e;
    if (sb.size() == 0) chk("extra_write", 32'(dc_wr_o), 32'd0);
    else begin
      e = sb.pop_front();
      chk("dc_addr", dc_addr_o, {e.wa, 2'b00});
      chk("dc_data", dc_data_o, e.data);
      chk("dc_be", 32'(dc_be_o), 32'(e.be));
    end
  endtask

  task automatic drain_one(input int unsigned dly, input bit chk_drn);
    wait_wr();
    check_head();
    repeat (dly) tick();
    chk("dc_wr_hold", 32'(dc_wr_o), 32'd1);
    if (chk_drn) chk("draining", 32'(draining_o), 32'd1);
    dc_ack_i = 1'b1;
    tick();
    dc_ack_i = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    bit seen;
    rsn_i = 1'b0; push_i = 1'b0; push_addr_i = '0; push_data_i = '0; push_type_i = WORD;
    ld_addr_i = '0; ld_type_i = WORD; cache_idle_i = 1'b0; drain_req_i = 1'b0; dc_ack_i = 1'b0;
    repeat (2) tick();
    chk("rst_dc_wr", 32'(dc_wr_o), 32'd0);
    chk("rst_fwd_hit", 32'(fwd_hit_o), 32'd0);
    chk("rst_fwd_partial", 32'(fwd_partial_o), 32'd0);
    chk("rst_draining", 32'(draining_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_ready", 32'(push_ready_o), 32'd1);
    rsn_i = 1'b1;
    tick();

    // word forwarding
    do_push(32'h100, 32'h11223344, WORD);
    lookup(32'h102, HALF, 1'b1, 1'b0, 1'b1, 32'h00001122);
    lookup(32'h100, WORD, 1'b1, 1'b0, 1'b1, 32'h11223344);
    lookup(32'h103, BYTE, 1'b1, 1'b0, 1'b1, 32'h00000011);
    chk("idle_no_wr", 32'(dc_wr_o), 32'd0);
    cache_idle_i = 1'b1;
    drain_one(0, 1'b0);
    cache_idle_i = 1'b0;
    chk("empty_after_word", 32'(empty_o), 32'd1);

    // partial coverage
    do_push(32'h201, 32'h000000AA, BYTE);
    lookup(32'h200, WORD, 1'b0, 1'b1, 1'b0, 32'h0);
    lookup(32'h201, BYTE, 1'b1, 1'b0, 1'b1, 32'h000000AA);
    lookup(32'h300, WORD, 1'b0, 1'b0, 1'b1, 32'h0);
    cache_idle_i = 1'b1;
    drain_one(0, 1'b0);
    cache_idle_i = 1'b0;

    // coalescing two bytes into one entry
    do_push(32'h300, 32'h00000055, BYTE);
    do_push(32'h303, 32'h00000066, BYTE);
    cache_idle_i = 1'b1;
    wait_wr();
    chk("merge_be", 32'(dc_be_o), 32'h9);
    chk("merge_data", dc_data_o, 32'h66000055);
    check_head();
    dc_ack_i = 1'b1; tick(); dc_ack_i = 1'b0;
    cache_idle_i = 1'b0;
    chk("merge_single_entry", 32'(empty_o), 32'd1);

    // misaligned pushes are dropped; flush on empty buffer stays clear
    do_push(32'h601, 32'h0000BEEF, HALF);
    do_push(32'h602, 32'hDEADBEEF, WORD);
    chk("misaligned_dropped", 32'(empty_o), 32'd1);
    drain_req_i = 1'b1; tick(); drain_req_i = 1'b0;
    chk("flush_empty", 32'(draining_o), 32'd0);

    // fill to DEPTH, wrap pointers
    for (int unsigned i = 0; i < DEPTH; i++)
      do_push(32'h400 + 4 * i, 32'h40000000 + i, WORD);
    chk("full_still_idle", 32'(dc_wr_o), 32'd0);
    do_push(32'h500, 32'h55555555, WORD);
    chk("issue_on_full", 32'(dc_wr_o), 32'd1);
    do_push(32'h40F, 32'h000000EE, BYTE);
    cache_idle_i = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) drain_one(0, 1'b0);
    cache_idle_i = 1'b0;
    chk("empty_after_fill", 32'(empty_o), 32'd1);

    // flush with 3 entries
    do_push(32'hB00, 32'hB0000000, WORD);
    do_push(32'hB04, 32'hB0000004, WORD);
    do_push(32'hB08, 32'hB0000008, WORD);
    drain_req_i = 1'b1; tick(); drain_req_i = 1'b0;
    chk("flush_set", 32'(draining_o), 32'd1);
    for (int unsigned i = 0; i < 3; i++) drain_one(1, 1'b1);
    chk("flush_done", 32'(draining_o), 32'd0);
    chk("flush_empty_o", 32'(empty_o), 32'd1);

    // allocate and pop in the same cycle
    do_push(32'hC00, 32'hC0C0C0C0, WORD);
    do_push(32'hC04, 32'hC4C4C4C4, WORD);
    cache_idle_i = 1'b1;
    wait_wr();
    check_head();
    dc_ack_i = 1'b1;
    do_push(32'hC08, 32'hC8C8C8C8, WORD);
    dc_ack_i = 1'b0;
    chk("pushpop_nonempty", 32'(empty_o), 32'd0);
    drain_one(0, 1'b0);
    drain_one(0, 1'b0);
    cache_idle_i = 1'b0;
    chk("pushpop_empty", 32'(empty_o), 32'd1);

    // reset in the middle of ISSUE
    do_push(32'hD00, 32'hD0000000, WORD);
    do_push(32'hD04, 32'hD0000004, WORD);
    cache_idle_i = 1'b1;
    wait_wr();
    rsn_i = 1'b0;
    #1;
    chk("midrst_dc_wr", 32'(dc_wr_o), 32'd0);
    chk("midrst_empty", 32'(empty_o), 32'd1);
    chk("midrst_ready", 32'(push_ready_o), 32'd1);
    chk("midrst_draining", 32'(draining_o), 32'd0);
    lookup(32'hD00, WORD, 1'b0, 1'b0, 1'b1, 32'h0);
    sb.delete();
    tick();
    rsn_i = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | dc_wr_o;
    end
    chk("no_wr_after_rst", 32'(seen), 32'd0);
    chk("empty_after_rst", 32'(empty_o), 32'd1);
    cache_idle_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
